mem_access_unit: RTL
====================

# mem_access_unit

Load/store unit that sits directly downstream of the EX-stage ALU. It takes the ALU result as the effective address, plus the store operand and a memory opcode. It runs one request/grant/response transaction on the data-memory port and returns a 64-bit writeback value. Loads are sign- or zero-extended; stores return zero. Misaligned accesses and memory timeouts are reported as errors instead of being issued or hung on.

## Interface
- TIMEOUT_CYCLES, 255: WAIT-state cycles before a timeout error; 0 disables the timeout; legal range 0..65535.
- clk  in  1  core clock, all state on rising edge
- rstn  in  1  asynchronous, active-low reset
- req_valid  in  1  EX stage presents an access
- req_ready  out  1  unit can accept (high only in IDLE)
- mem_op  in  4  [3]=store, [2]=unsigned (ignored for stores), [1:0]=size: 0 byte, 1 half, 2 word, 3 double
- addr  in  64  effective address (ALU result)
- wdata  in  64  store data, right-aligned (rs2)
- mem_req  out  1  memory request
- mem_gnt  in  1  memory accepts request
- mem_addr  out  64  {addr[63:3], 3'b000}
- mem_wen  out  1  1 = write
- mem_wmask  out  8  byte enables
- mem_wdata  out  64  lane-shifted store data
- mem_rvalid  in  1  response/ack from memory
- mem_rdata  in  64  raw doubleword read data
- resp_valid  out  1  result available
- resp_ready  in  1  writeback consumes result
- resp_data  out  64  extended load value; 0 for stores and errors
- resp_err  out  2  00 ok, 01 misaligned, 10 timeout

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: req_ready=1. If req_valid, latch mem_op, addr, wdata.
  - Misaligned: half with addr[0]!=0, word with addr[1:0]!=0, double with addr[2:0]!=0. On misaligned, go to RESP with resp_err=01 and no memory access.
  - Otherwise go to REQ.
- REQ: mem_req=1, and mem_addr/mem_wen/mem_wmask/mem_wdata are held stable until mem_gnt. On mem_gnt, go to WAIT.
- WAIT: mem_req=0.
  - On mem_rvalid, register the result and go to RESP with err 00.
  - Each cycle without mem_rvalid increments a 16-bit counter. If the counter equals TIMEOUT_CYCLES (nonzero), go to RESP with err 10.
  - mem_rvalid in the same cycle as the timeout wins (err 00).
- RESP: resp_valid=1 with resp_data/resp_err stable until resp_ready, then go to IDLE. The counter is cleared on leaving WAIT.
- Store lanes: off=addr[2:0].
  - mem_wmask = ((1<<(1<<size))-1) << off, truncated to 8 bits.
  - mem_wdata = wdata << (8*off). Loads drive mask 0 and wdata 0.
- Load extraction: sh = mem_rdata >> (8*off). Take the low 8/16/32/64 bits per size. Sign-extend from the top bit unless unsigned; zero-extend if unsigned. A double ignores the unsigned bit.
- mem_rvalid outside WAIT is ignored. mem_gnt outside REQ is ignored.

## Timing
- Reset (asynchronous, rstn=0):
  - FSM returns to IDLE and the counter clears.
  - req_ready=1 while in reset.
  - mem_req, mem_wen, resp_valid = 0; mem_addr, mem_wmask, mem_wdata, resp_data = 0; resp_err = 00.
  - Reset mid-transaction drops the access; the memory side is reset together with this unit.
- Outputs are registers or decodes of registered state only. There is no combinational path from any input to any output.
- Accept at edge 0 → mem_req high in cycle 1.
- If mem_gnt is in cycle 1, WAIT is cycle 2. If mem_rvalid is in cycle 2, resp_valid is high in cycle 3. Minimum latency is 3 cycles.
- Misaligned: resp_valid in cycle 1.
- resp_valid and resp_ready in the same cycle → IDLE next cycle, so back-to-back accesses take at least 4 cycles each.
- One outstanding transaction; no pipelining.

## Test plan
- LB at addr 0x1003, mem_rdata=0x0000_0000_8000_0000 → mem_addr 0x1000, mem_wmask 0x00, resp_data 0xFFFF_FFFF_FFFF_FF80, err 00. Repeat as LBU → 0x80.
- SH wdata=0xABCD at addr 0x2006, gnt immediate, rvalid next cycle → mem_wen=1, mem_wmask 0xC0, mem_wdata 0xABCD_0000_0000_0000, resp_data 0, resp_valid exactly 3 cycles after accept.
- LW at 0x3002 → no mem_req at any time, resp_valid in cycle 1, err 01, resp_data 0. Also LD at 0x3004 → err 01; LD at 0x3000 issues normally.
- LWU at 0x4004 with mem_gnt held low 5 cycles → mem_req and mem_addr stable all 5 cycles. With mem_rdata=0xF000_0000_1234_5678 → resp_data 0x0000_0000_F000_0000.
- TIMEOUT_CYCLES=4, no mem_rvalid → err 10 after the 4th WAIT cycle. Second run with rvalid in that same cycle → err 00.
- Deassert rstn while in WAIT, mid-cycle → all outputs reach reset values immediately. After release, a fresh LD completes normally. resp_ready held low 3 cycles in RESP → resp_data stable, req_ready=0.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit: one request/grant/response access on the data-memory port.
// Returns the extended load value or zero, plus a misaligned/timeout status.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  mem_op,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [63:0] mem_addr,
    output logic        mem_wen,
    output logic [7:0]  mem_wmask,
    output logic [63:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_data,
    output logic [1:0]  resp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [16:0] TO_LIMIT = 17'(TIMEOUT_CYCLES);

    state_t      state_q;
    logic [15:0] cnt_q;
    logic        st_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [2:0]  off_q;
    logic [63:0] mem_addr_q;
    logic        mem_wen_q;
    logic [7:0]  mem_wmask_q;
    logic [63:0] mem_wdata_q;
    logic [63:0] resp_data_q;
    logic [1:0]  resp_err_q;

    logic        misal;
    logic [7:0]  lanes;
    logic [7:0]  wmask_d;
    logic [63:0] wdata_d;
    logic [63:0] sh;
    logic [63:0] ld_data_d;
    logic [16:0] cnt_inc;

    always_comb begin
        misal = 1'b0;
        lanes = 8'h01;
        unique case (mem_op[1:0])
            2'd0: begin
                misal = 1'b0;
                lanes = 8'h01;
            end
            2'd1: begin
                misal = addr[0];
                lanes = 8'h03;
            end
            2'd2: begin
                misal = |addr[1:0];
                lanes = 8'h0F;
            end
            2'd3: begin
                misal = |addr[2:0];
                lanes = 8'hFF;
            end
        endcase
        wmask_d = mem_op[3] ? (lanes << addr[2:0]) : 8'h00;
        wdata_d = mem_op[3] ? (wdata << {addr[2:0], 3'b000}) : 64'd0;
    end

    always_comb begin
        sh = mem_rdata >> {off_q, 3'b000};
        ld_data_d = sh;
        unique case (size_q)
            2'd0: ld_data_d = uns_q ? {56'd0, sh[7:0]}
                                    : {{56{sh[7]}}, sh[7:0]};
            2'd1: ld_data_d = uns_q ? {48'd0, sh[15:0]}
                                    : {{48{sh[15]}}, sh[15:0]};
            2'd2: ld_data_d = uns_q ? {32'd0, sh[31:0]}
                                    : {{32{sh[31]}}, sh[31:0]};
            2'd3: ld_data_d = sh;
        endcase
    end

    assign cnt_inc = {1'b0, cnt_q} + 17'd1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            st_q        <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= '0;
            off_q       <= '0;
            mem_addr_q  <= '0;
            mem_wen_q   <= 1'b0;
            mem_wmask_q <= '0;
            mem_wdata_q <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 2'b00;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        st_q   <= mem_op[3];
                        uns_q  <= mem_op[2];
                        size_q <= mem_op[1:0];
                        off_q  <= addr[2:0];
                        if (misal) begin
                            resp_data_q <= '0;
                            resp_err_q  <= 2'b01;
                            state_q     <= RESP;
                        end else begin
                            mem_addr_q  <= {addr[63:3], 3'b000};
                            mem_wen_q   <= mem_op[3];
                            mem_wmask_q <= wmask_d;
                            mem_wdata_q <= wdata_d;
                            state_q     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) state_q <= WAIT;
                end
                WAIT: begin
                    // A response arriving on the timeout cycle still wins.
                    if (mem_rvalid) begin
                        resp_data_q <= st_q ? 64'd0 : ld_data_d;
                        resp_err_q  <= 2'b00;
                        cnt_q       <= '0;
                        state_q     <= RESP;
                    end else if (TO_LIMIT != 17'd0 && cnt_inc == TO_LIMIT) begin
                        resp_data_q <= '0;
                        resp_err_q  <= 2'b10;
                        cnt_q       <= '0;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_inc[15:0];
                    end
                end
                RESP: begin
                    if (resp_ready) state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign mem_req    = (state_q == REQ);
    assign resp_valid = (state_q == RESP);
    assign mem_addr   = mem_addr_q;
    assign mem_wen    = mem_wen_q;
    assign mem_wmask  = mem_wmask_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;

endmodule
